neuron_mac_seq: RTL and testbench

Sequential single-neuron evaluator that consumes the weight memory of the autoencoder datapath. On `start` it latches an input vector, walks the weight memory two words per cycle through two read ports, accumulates signed Q8.8 products, adds the bias word stored after the weights, and applies ReLU with saturation. The result is presented on `y_out` with a one-cycle `y_valid` strobe. It sits directly downstream of the weight memory and drives that memory's read addresses.

---
 rtl/neuron_mac_seq.sv | 145 ++++++++++++++
 tb/tb_neuron_mac_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// Sequential single-neuron evaluator: two weight words per cycle from a dual-read
// weight memory, signed Q8.8 multiply-accumulate, bias add, then ReLU with saturation.
module neuron_mac_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int N_IN       = 8,
   parameter int FRAC_BITS  = 8,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [N_IN*DATA_WIDTH-1:0]     x_in,
   output logic [ADDR_WIDTH-1:0]          read_addr_1,
   output logic [ADDR_WIDTH-1:0]          read_addr_2,
   input  logic [DATA_WIDTH-1:0]          read_data_1,
   input  logic [DATA_WIDTH-1:0]          read_data_2,
   output logic                           busy,
   output logic [DATA_WIDTH-1:0]          y_out,
   output logic                           y_valid,
   output logic [1:0]                     dbg_state
);

   localparam int P  = (N_IN + 1) / 2;
   localparam int XW = 2 * P * DATA_WIDTH;
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_BIAS = 2'd2
   } state_t;

   state_t                        r_state;
   logic [ADDR_WIDTH-1:0]         r_k;
   logic signed [ACC_WIDTH-1:0]   r_acc;
   logic [XW-1:0]                 r_x;
   logic [ADDR_WIDTH-1:0]         r_addr_1;
   logic [ADDR_WIDTH-1:0]         r_addr_2;
   logic [DATA_WIDTH-1:0]         r_y;
   logic                          r_valid;

   logic [DATA_WIDTH-1:0]         w_xa;
   logic [DATA_WIDTH-1:0]         w_xb;
   logic signed [PW-1:0]          w_prod_a;
   logic signed [PW-1:0]          w_prod_b;
   logic signed [ACC_WIDTH-1:0]   w_mac_sum;
   logic signed [ACC_WIDTH-1:0]   w_bias_sh;
   logic signed [ACC_WIDTH-1:0]   w_s;
   logic signed [ACC_WIDTH-1:0]   w_r;
   logic [DATA_WIDTH-1:0]         w_y_sat;
   logic [ADDR_WIDTH-1:0]         w_k_nxt;

   // For odd N_IN the latched vector is zero-padded to 2*P elements, so the
   // unused second product of the last pair is zero whatever the memory returns.
   always_comb begin
      w_xa = '0;
      w_xb = '0;
      for (int j = 0; j < P; j++) begin
         if (r_k == ADDR_WIDTH'(j)) begin
            w_xa = r_x[(2*j)*DATA_WIDTH   +: DATA_WIDTH];
            w_xb = r_x[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign w_prod_a  = $signed({{DATA_WIDTH{read_data_1[DATA_WIDTH-1]}}, read_data_1})
                    * $signed({{DATA_WIDTH{w_xa[DATA_WIDTH-1]}}, w_xa});
   assign w_prod_b  = $signed({{DATA_WIDTH{read_data_2[DATA_WIDTH-1]}}, read_data_2})
                    * $signed({{DATA_WIDTH{w_xb[DATA_WIDTH-1]}}, w_xb});
   assign w_mac_sum = r_acc
                    + $signed({{(ACC_WIDTH-PW){w_prod_a[PW-1]}}, w_prod_a})
                    + $signed({{(ACC_WIDTH-PW){w_prod_b[PW-1]}}, w_prod_b});

   // Bias is a Q8.8 word; shift it up to the Q16.16 scale of the accumulator.
   assign w_bias_sh = $signed({{(ACC_WIDTH-DATA_WIDTH){read_data_1[DATA_WIDTH-1]}}, read_data_1})
                    <<< FRAC_BITS;
   assign w_s       = r_acc + w_bias_sh;
   assign w_r       = w_s >>> FRAC_BITS;

   always_comb begin
      w_y_sat = w_r[DATA_WIDTH-1:0];
      if (w_r[ACC_WIDTH-1])
         w_y_sat = '0;
      else if (|w_r[ACC_WIDTH-2:DATA_WIDTH-1])
         w_y_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   end

   assign w_k_nxt = r_k + ADDR_WIDTH'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_k      <= '0;
         r_acc    <= '0;
         r_x      <= '0;
         r_addr_1 <= ADDR_WIDTH'(0);
         r_addr_2 <= ADDR_WIDTH'(1);
         r_y      <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x      <= XW'(x_in);
                  r_acc    <= '0;
                  r_k      <= '0;
                  r_addr_1 <= ADDR_WIDTH'(0);
                  r_addr_2 <= ADDR_WIDTH'(1);
                  r_state  <= S_MAC;
               end
            end
            S_MAC: begin
               r_acc <= w_mac_sum;
               if (r_k == ADDR_WIDTH'(P-1)) begin
                  r_addr_1 <= ADDR_WIDTH'(N_IN);
                  r_addr_2 <= ADDR_WIDTH'(N_IN);
                  r_state  <= S_BIAS;
               end else begin
                  r_k      <= w_k_nxt;
                  r_addr_1 <= {w_k_nxt[ADDR_WIDTH-2:0], 1'b0};
                  r_addr_2 <= {w_k_nxt[ADDR_WIDTH-2:0], 1'b1};
               end
            end
            S_BIAS: begin
               r_y      <= w_y_sat;
               r_valid  <= 1'b1;
               r_addr_1 <= ADDR_WIDTH'(0);
               r_addr_2 <= ADDR_WIDTH'(1);
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign read_addr_1 = r_addr_1;
   assign read_addr_2 = r_addr_2;
   assign busy        = (r_state != S_IDLE);
   assign y_out       = r_y;
   assign y_valid     = r_valid;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: an N_IN=8 instance and an N_IN=3 instance,
// each fed by a combinational weight-memory model.
module tb_neuron_mac_seq;

   logic         clk;
   logic         rst;

   logic         start8;
   logic [127:0] x8;
   logic [3:0]   ra1_8, ra2_8;
   logic [15:0]  rd1_8, rd2_8;
   logic         busy8, yv8;
   logic [15:0]  y8;
   logic [1:0]   st8;
   logic [15:0]  mem8 [16];

   logic         start3;
   logic [47:0]  x3;
   logic [3:0]   ra1_3, ra2_3;
   logic [15:0]  rd1_3, rd2_3;
   logic         busy3, yv3;
   logic [15:0]  y3;
   logic [1:0]   st3;
   logic [15:0]  mem3 [16];

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] exp_q[$];

   neuron_mac_seq #(.N_IN(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .x_in(x8),
      .read_addr_1(ra1_8), .read_addr_2(ra2_8),
      .read_data_1(rd1_8), .read_data_2(rd2_8),
      .busy(busy8), .y_out(y8), .y_valid(yv8), .dbg_state(st8)
   );

   neuron_mac_seq #(.N_IN(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .x_in(x3),
      .read_addr_1(ra1_3), .read_addr_2(ra2_3),
      .read_data_1(rd1_3), .read_data_2(rd2_3),
      .busy(busy3), .y_out(y3), .y_valid(yv3), .dbg_state(st3)
   );

   assign rd1_8 = mem8[ra1_8];
   assign rd2_8 = mem8[ra2_8];
   assign rd1_3 = mem3[ra1_3];
   // Address 3 returns junk while it is the padding slot of pair 1, bias otherwise.
   assign rd2_3 = (ra1_3 == 4'd2 && ra2_3 == 4'd3) ? 16'h7FFF : mem3[ra2_3];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic load8(input logic [15:0] w_even, input logic [15:0] w_odd,
                        input logic [15:0] xv, input logic [15:0] bias);
      for (int i = 0; i < 16; i++) mem8[i] = 16'h0;
      for (int i = 0; i < 8; i++) begin
         mem8[i] = (i % 2 == 0) ? w_even : w_odd;
         x8[i*16 +: 16] = xv;
      end
      mem8[8] = bias;
   endtask

   // Pulses start for one edge, then waits (bounded) for y_valid; lat counts edges.
   task automatic run8(output int lat);
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = 0;
      while (!yv8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_and_score8(input string tag);
      int lat;
      run8(lat);
      check({tag, "_lat"}, lat, 5);
      if (exp_q.size() > 0) check({tag, "_y"}, y8, exp_q.pop_front());
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat;
      int n_valid;
      int valid_edges[$];

      rst = 1'b1; start8 = 1'b0; start3 = 1'b0; x8 = '0; x3 = '0;
      for (int i = 0; i < 16; i++) begin mem8[i] = 16'h0; mem3[i] = 16'h0; end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy8, 0);
      check("rst_valid", yv8, 0);
      check("rst_y", y8, 0);
      check("rst_addr1", ra1_8, 0);
      check("rst_addr2", ra2_8, 1);
      check("rst_state", st8, 0);
      @(negedge clk) rst = 1'b0;

      // Ones: 8 * 1.0 * 1.0 + 0 = 8.0, with address walk and strobe timing.
      load8(16'h0100, 16'h0100, 16'h0100, 16'h0000);
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      for (int p = 0; p < 5; p++) begin
         check($sformatf("walk%0d_a1", p), ra1_8, (p < 4) ? 2*p : 8);
         check($sformatf("walk%0d_a2", p), ra2_8, (p < 4) ? 2*p+1 : 8);
         check($sformatf("walk%0d_busy", p), busy8, 1);
         check($sformatf("walk%0d_valid", p), yv8, 0);
         @(posedge clk); #1;
      end
      check("ones_valid", yv8, 1);
      check("ones_y", y8, 16'h0800);
      check("ones_busy", busy8, 0);
      check("ones_addr_idle", {ra1_8, ra2_8}, 8'h01);
      @(posedge clk); #1;
      check("ones_strobe_1cyc", yv8, 0);
      check("ones_y_held", y8, 16'h0800);

      // -1.0 weights: -8 + 2 = -6 -> ReLU.
      load8(16'hFF00, 16'hFF00, 16'h0100, 16'h0200);
      exp_q.push_back(16'h0000);
      run_and_score8("relu");

      // 127*127*8 overflows Q8.8 -> saturate.
      load8(16'h7F00, 16'h7F00, 16'h7F00, 16'h0000);
      exp_q.push_back(16'h7FFF);
      run_and_score8("sat");

      // 0.5 * (1+..+8) + 1.0 = 19.0
      load8(16'h0080, 16'h0080, 16'h0000, 16'h0100);
      for (int i = 0; i < 8; i++) x8[i*16 +: 16] = 16'((i + 1) * 256);
      exp_q.push_back(16'h1300);
      run_and_score8("ramp");

      // Pairs (1.0, -0.5) * 2.0 -> 4 * 1.0, bias -1.0 -> 3.0
      load8(16'h0100, 16'hFF80, 16'h0200, 16'hFF00);
      exp_q.push_back(16'h0300);
      run_and_score8("mixsign");

      // Tiny values: 8 * 0x10*0x10 = 2048 raw -> 8 LSB after shift.
      load8(16'h0010, 16'h0010, 16'h0010, 16'h0000);
      exp_q.push_back(16'h0008);
      run_and_score8("tiny");

      // Odd N_IN: 1+2+3 = 6.0, bias 0.5, junk at addr 3 during pair 1 ignored.
      mem3[0] = 16'h0100; mem3[1] = 16'h0200; mem3[2] = 16'h0300; mem3[3] = 16'h0080;
      x3 = {16'h0100, 16'h0100, 16'h0100};
      start3 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      lat = 0;
      while (!yv3 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("odd_lat", lat, 3);
      check("odd_y", y3, 16'h0680);

      // Start held high: results at edges 5, 11, 17 only.
      load8(16'h0100, 16'h0100, 16'h0100, 16'h0000);
      start8 = 1'b1;
      for (int e = 0; e < 18; e++) begin
         @(posedge clk); #1;
         if (yv8) valid_edges.push_back(e);
      end
      start8 = 1'b0;
      n_valid = valid_edges.size();
      check("b2b_count", n_valid, 3);
      for (int i = 0; i < 3; i++)
         check($sformatf("b2b_edge%0d", i), (i < n_valid) ? valid_edges[i] : -1, 5 + 6*i);
      check("b2b_y", y8, 16'h0800);
      repeat (8) @(posedge clk);
      #1;
      check("b2b_idle", busy8, 0);

      // Reset during MAC k=2 aborts without a strobe.
      load8(16'h0200, 16'h0200, 16'h0100, 16'h0000);
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_state_mac", st8, 1);
      rst = 1'b1;
      #1;
      check("abort_busy", busy8, 0);
      check("abort_y", y8, 0);
      @(negedge clk) rst = 1'b0;
      n_valid = 0;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk); #1;
         if (yv8) n_valid++;
      end
      check("abort_no_valid", n_valid, 0);
      // 8 * 2.0 = 16.0
      exp_q.push_back(16'h1000);
      run_and_score8("after_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
